// File: rtl/phy_pkg.sv
// Shared PHY definitions: sync-state codes and K-symbols used by both the
// receive aligner and the transmit-side idle logic.
package phy_pkg;

    // Alignment states; encoding 2'b11 is unused and recovers to SEARCH
    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        ALIGN  = 2'b01,
        ACTIVE = 2'b10
    } sync_state_t;

    // K-symbols
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_IDL = 8'h7C;

    // Aligned COMs needed before the link is declared active
    localparam int COM_LOCK_DEFAULT = 4;

endpackage

// File: rtl/rx_shift8.sv
// Serial shift register plus symbol bit counter. Presents the byte that
// would be formed by the bit arriving this cycle (nb) so the FSM can decide
// on the same edge that samples a symbol's last bit.
module rx_shift8
    import phy_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_serial,
    input  logic              realign,
    output logic [DATA_W-1:0] nb,
    output logic              at_boundary
);

    localparam int              CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    // Only the newest DATA_W-1 bits are ever read back, so the oldest bit of
    // the shift register is not stored.
    logic [DATA_W-2:0] hist;
    logic [CNT_W-1:0]  bit_cnt;

    assign nb          = {hist, in_serial};
    assign at_boundary = (bit_cnt == LAST);

    // Shift in one bit per edge; the counter wraps at the symbol boundary or
    // is pulled back to 0 when the FSM finds a new alignment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist    <= '0;
            bit_cnt <= '0;
        end else begin
            hist <= nb[DATA_W-2:0];
            if (realign || at_boundary) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: finds byte alignment on COM, declares the
// link active after COM_LOCK aligned COMs and delivers data bytes with a
// one-cycle valid strobe.
// Optional feature: define RX_IDLE_DROP_EN to discard IDL symbols in ACTIVE.
module serial_to_parallel_rx
    import phy_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] COM      = DATA_W'(K_COM),
    parameter logic [DATA_W-1:0] IDL      = DATA_W'(K_IDL),
    parameter int                COM_LOCK = COM_LOCK_DEFAULT
) (
    input  logic              clk32f,
    input  logic              reset,
    input  logic              in_serial,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              active,
    output logic [1:0]        sync_st
);

`ifdef RX_IDLE_DROP_EN
    localparam bit DROP_IDL = 1'b1;
`else
    localparam bit DROP_IDL = 1'b0;
`endif

    localparam logic [3:0] LOCK = 4'(COM_LOCK);

    sync_state_t       state, state_d;
    logic [3:0]        com_cnt, com_cnt_d, com_inc;
    logic [DATA_W-1:0] data_d;
    logic              valid_d;
    logic              realign;
    logic [DATA_W-1:0] nb;
    logic              at_boundary;
    logic              is_fill;

    rx_shift8 #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk         (clk32f),
        .reset       (reset),
        .in_serial   (in_serial),
        .realign     (realign),
        .nb          (nb),
        .at_boundary (at_boundary)
    );

    // Fill symbols never reach the demux: COM always, IDL only when dropping
    assign is_fill = (nb == COM) || (DROP_IDL && (nb == IDL));
    assign com_inc = com_cnt + 4'd1;

    // Next-state, COM counting and data capture decisions
    always_comb begin
        state_d   = state;
        com_cnt_d = com_cnt;
        data_d    = out_data;
        valid_d   = 1'b0;
        realign   = 1'b0;
        case (state)
            SEARCH: begin
                // Bit-level hunt: any position may start a symbol
                if (nb == COM) begin
                    realign   = 1'b1;
                    com_cnt_d = 4'd1;
                    if (COM_LOCK == 1) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (at_boundary) begin
                    if (nb == COM) begin
                        com_cnt_d = com_inc;
                        if (com_inc == LOCK) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Sticky until reset; unaligned COM look-alikes are ignored
                if (at_boundary && !is_fill) begin
                    data_d  = nb;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = SEARCH;
                com_cnt_d = '0;
            end
        endcase
    end

    // State, COM counter and registered outputs
    always_ff @(posedge clk32f or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            com_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            com_cnt   <= com_cnt_d;
            out_data  <= data_d;
            out_valid <= valid_d;
        end
    end

    assign active  = (state == ACTIVE);
    assign sync_st = state;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Testbench for serial_to_parallel_rx: directed and random serial streams
// compared against a stream-level reference model (alignment is tracked as
// the bit index of the last SEARCH hit, symbol boundaries by modulo 8).
module tb_serial_to_parallel_rx;

    localparam int COM_LOCK = 4;
`ifdef RX_IDLE_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic       clk32f    = 1'b0;
    logic       reset     = 1'b1;
    logic       in_serial = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       active;
    logic [1:0] sync_st;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    // Reference model state
    int         m_n, m_anchor, m_coms, m_mode;   // m_mode: 0 SEARCH, 1 ALIGN, 2 ACTIVE
    logic [7:0] m_win, m_data;
    logic       m_valid;

    serial_to_parallel_rx #(
        .DATA_W   (8),
        .COM      (8'hBC),
        .IDL      (8'h7C),
        .COM_LOCK (COM_LOCK)
    ) dut (
        .clk32f    (clk32f),
        .reset     (reset),
        .in_serial (in_serial),
        .out_data  (out_data),
        .out_valid (out_valid),
        .active    (active),
        .sync_st   (sync_st)
    );

    always #5 clk32f = ~clk32f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_anchor = 0; m_coms = 0; m_mode = 0;
        m_win = 8'h00; m_data = 8'h00; m_valid = 1'b0;
    endtask

    // Stream-level rules: find COM anywhere while searching, afterwards only
    // look at windows whose end is a multiple of 8 bits past the hit.
    task automatic model_edge(input logic b);
        m_n++;
        m_win   = {m_win[6:0], b};
        m_valid = 1'b0;
        if (m_mode == 0) begin
            if (m_win == 8'hBC) begin
                m_anchor = m_n;
                m_coms   = 1;
                m_mode   = (COM_LOCK == 1) ? 2 : 1;
            end
        end else if (((m_n - m_anchor) % 8) == 0) begin
            if (m_mode == 1) begin
                if (m_win == 8'hBC) begin
                    m_coms++;
                    if (m_coms == COM_LOCK) m_mode = 2;
                end else begin
                    m_coms = 0;
                    m_mode = 0;
                end
            end else if (!(m_win == 8'hBC || (DROP && m_win == 8'h7C))) begin
                m_data  = m_win;
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic step(input logic b);
        @(negedge clk32f);
        in_serial = b;
        @(posedge clk32f);
        model_edge(b);
        #1;
        check("valid",   {7'b0, out_valid}, {7'b0, m_valid});
        check("active",  {7'b0, active},    {7'b0, (m_mode == 2)});
        check("sync_st", {6'b0, sync_st},   8'(m_mode));
        check("data",    out_data,          m_data);
        if (out_valid) strobes++;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"},  {7'b0, out_valid}, 8'h00);
        check({tag, "_active"}, {7'b0, active},    8'h00);
        check({tag, "_data"},   out_data,          8'h00);
        check({tag, "_sync"},   {6'b0, sync_st},   8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [7:0] bv;

        // 1: reset held low with random serial activity
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk32f);
            in_serial = 1'($urandom);
            @(posedge clk32f);
            #1 check_zero("rst_hold");
        end
        @(negedge clk32f);
        reset = 1'b1;
        model_reset();

        // 2: junk bits, four COMs, then A5
        for (int i = 0; i < 3; i++) step(1'($urandom));
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'hBC);
        bv = 8'hBC;
        for (int i = 7; i >= 1; i--) step(bv[i]);
        check("t2_before_lock", {7'b0, active}, 8'h00);
        step(bv[0]);
        check("t2_lock", {7'b0, active}, 8'h01);
        s0 = strobes;
        send_byte(8'hA5);
        check("t2_data",  out_data, 8'hA5);
        check("t2_valid", {7'b0, out_valid}, 8'h01);

        // 4: data with COM and IDL mixed in
        s0 = strobes;
        send_byte(8'h11);
        check("t4_11", out_data, 8'h11);
        send_byte(8'hBC);
        check("t4_bc_nostrobe", {7'b0, out_valid}, 8'h00);
        send_byte(8'h22);
        check("t4_22", out_data, 8'h22);
        send_byte(8'h7C);
        check("t4_idl_valid", {7'b0, out_valid}, DROP ? 8'h00 : 8'h01);
        check("t4_idl_data",  out_data,          DROP ? 8'h22 : 8'h7C);
        send_byte(8'h33);
        check("t4_33", out_data, 8'h33);
        check("t4_count", 8'(strobes - s0), DROP ? 8'd3 : 8'd4);

        // 5: unaligned COM pattern across two data bytes
        send_byte(8'h5E);
        check("t5_5e", out_data, 8'h5E);
        send_byte(8'h1F);
        check("t5_1f", out_data, 8'h1F);
        check("t5_sync", {6'b0, sync_st}, 8'h02);

        // 6: asynchronous reset mid-byte while ACTIVE
        for (int i = 0; i < 3; i++) step(1'($urandom));
        #2 reset = 1'b0;
        #1 check_zero("t6_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk32f);
            in_serial = 1'($urandom);
            @(posedge clk32f);
            #1 check_zero("t6_hold");
        end
        @(negedge clk32f);
        reset = 1'b1;
        model_reset();

        // 3: failed alignment falls back to SEARCH, then re-lock
        s0 = strobes;
        send_byte(8'hBC);
        check("t3_align1", {6'b0, sync_st}, 8'h01);
        send_byte(8'hBC);
        check("t3_align2", {6'b0, sync_st}, 8'h01);
        send_byte(8'h3C);
        check("t3_search", {6'b0, sync_st}, 8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("t3_relock",    {7'b0, active}, 8'h01);
        check("t3_no_strobe", 8'(strobes - s0), 8'h00);

        // Random byte stream on a locked link
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       send_byte(8'hBC);
                1:       send_byte(8'h7C);
                default: send_byte(8'($urandom));
            endcase
        end

        // Random bit-level acquisition after a fresh reset
        @(negedge clk32f);
        reset = 1'b0;
        @(negedge clk32f);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 60; i++) step(1'($urandom));
        for (int i = 0; i < 5; i++) send_byte(8'hBC);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) send_byte(8'hBC);
            else send_byte(8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
